// File: rtl/seg_scan_ctrl.sv
// Multiplexed N-digit 7-segment scan driver with hex decode, LZ suppression and PWM.
// Optional blink support is built when SEG_SCAN_BLINK_EN is defined.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS     = 8,
    parameter int SCAN_DIV_LOG2  = 14,
    parameter int BRIGHT_W       = 3,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int BLINK_LOG2     = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] hex_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
`ifdef SEG_SCAN_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_in,
`endif
    input  logic                    lz_suppress,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_tick
);

    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic DP_OFF = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF =
        (AN_ACTIVE_LOW != 0) ? '1 : '0;

    if (SCAN_DIV_LOG2 < BRIGHT_W || BLINK_LOG2 < 1) begin : g_cfg_err
        $fatal(1, "seg_scan_ctrl: bad parameter set");
    end

    logic [SCAN_DIV_LOG2-1:0] presc;
    logic [IDX_W-1:0]         idx;
    logic [4*NUM_DIGITS-1:0]  sh_hex;
    logic [NUM_DIGITS-1:0]    sh_dp;
    logic [NUM_DIGITS-1:0]    sh_blank;

    logic                     wrap;
    logic                     last;
    logic [3:0]               digit;
    logic [NUM_DIGITS-1:0]    lz_run;
    logic                     suppressed;
    logic                     dark;
    logic                     pwm_on;
    logic [BRIGHT_W-1:0]      frac;
    logic [6:0]               glyph;
    logic [6:0]               lit_seg;
    logic                     lit_dp;
    logic [NUM_DIGITS-1:0]    lit_an;

`ifdef SEG_SCAN_BLINK_EN
    logic [NUM_DIGITS-1:0]    sh_blink;
    logic [BLINK_LOG2-1:0]    frame_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_blink  <= '0;
            frame_cnt <= '0;
        end else begin
            if (load)
                sh_blink <= blink_in;
            if (frame_tick)
                frame_cnt <= frame_cnt + 1'b1;
        end
    end

    assign dark = sh_blank[idx] | (sh_blink[idx] & frame_cnt[BLINK_LOG2-1]);
`else
    assign dark = sh_blank[idx];
`endif

    assign wrap  = &presc;
    assign last  = (idx == IDX_W'(NUM_DIGITS - 1));
    assign digit = sh_hex[4*idx +: 4];
    assign frac  = presc[SCAN_DIV_LOG2-1 -: BRIGHT_W];
    assign pwm_on = (&brightness) || (frac < brightness);

    // lz_run[i]: shadow digits NUM_DIGITS-1 down to i are all zero
    always_comb begin
        lz_run = '0;
        lz_run[NUM_DIGITS-1] = (sh_hex[4*(NUM_DIGITS-1) +: 4] == 4'd0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--)
            lz_run[i] = lz_run[i+1] && (sh_hex[4*i +: 4] == 4'd0);
    end

    assign suppressed = lz_suppress && (idx != '0) && lz_run[idx];

    always_comb begin
        glyph = 7'h00;
        unique case (digit)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            4'hF: glyph = 7'h71;
        endcase
    end

    always_comb begin
        lit_seg = (suppressed || dark) ? 7'h00 : glyph;
        lit_dp  = dark ? 1'b0 : sh_dp[idx];
        lit_an  = (dark || !pwm_on) ? '0 : (NUM_DIGITS'(1) << idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc      <= '0;
            idx        <= '0;
            sh_hex     <= '0;
            sh_dp      <= '0;
            sh_blank   <= '1;
            seg_out    <= SEG_OFF;
            dp_out     <= DP_OFF;
            an_out     <= AN_OFF;
            frame_tick <= 1'b0;
        end else begin
            presc      <= presc + 1'b1;
            frame_tick <= wrap && last;
            if (wrap)
                idx <= last ? '0 : idx + 1'b1;
            if (load) begin
                sh_hex   <= hex_in;
                sh_dp    <= dp_in;
                sh_blank <= blank_in;
            end
            seg_out <= lit_seg ^ SEG_OFF;
            dp_out  <= lit_dp ^ DP_OFF;
            an_out  <= lit_an ^ AN_OFF;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: 8 digits, 16-cycle slots, 3-bit brightness, active-low pins.
// Reference model derives every pin from the cycle position since reset and the latched display.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [31:0] hex_in;
    logic [7:0]  dp_in;
    logic [7:0]  blank_in;
    logic        lz_suppress;
    logic [2:0]  brightness;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [7:0]  an_out;
    logic        frame_tick;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .NUM_DIGITS(8),
        .SCAN_DIV_LOG2(4),
        .BRIGHT_W(3),
        .SEG_ACTIVE_LOW(1),
        .AN_ACTIVE_LOW(1),
        .BLINK_LOG2(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .hex_in(hex_in),
        .dp_in(dp_in),
        .blank_in(blank_in),
        .lz_suppress(lz_suppress),
        .brightness(brightness),
        .seg_out(seg_out),
        .dp_out(dp_out),
        .an_out(an_out),
        .frame_tick(frame_tick)
    );

    int errors = 0;
    int checks = 0;

    // model: latched display and scan position (cycles since reset)
    logic [31:0] m_hex;
    logic [7:0]  m_dp;
    logic [7:0]  m_blank;
    int          m_pos;
    logic [6:0]  glyph_tab [16];

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc();
        int p, i, frac;
        bit on, lzd;
        logic [31:0] upper;
        logic [7:0] an_exp;
        logic [6:0] seg_exp;
        @(posedge clk);
        #1;
        if (rst) begin
            chk("rst_an", an_out, 8'hFF);
            chk("rst_seg", {1'b0, seg_out}, 8'h7F);
            chk("rst_dp", {7'd0, dp_out}, 8'h01);
            chk("rst_ft", {7'd0, frame_tick}, 8'h00);
            m_pos   = 0;
            m_hex   = '0;
            m_dp    = '0;
            m_blank = '1;
        end else begin
            p     = m_pos % 16;
            i     = (m_pos / 16) % 8;
            frac  = p / 2;
            on    = (brightness == 3'd7) || (frac < int'(brightness));
            upper = m_hex >> (4 * i);
            lzd   = lz_suppress && (i > 0) && (upper == 0);
            an_exp = (on && !m_blank[i]) ? ~(8'd1 << i) : 8'hFF;
            seg_exp = lzd ? 7'h7F : ~glyph_tab[upper[3:0]];
            chk("an", an_out, an_exp);
            chk("frame_tick", {7'd0, frame_tick},
                {7'd0, 1'((m_pos % 128) == 127)});
            if (an_exp != 8'hFF) begin
                chk("seg", {1'b0, seg_out}, {1'b0, seg_exp});
                chk("dp", {7'd0, dp_out}, {7'd0, ~m_dp[i]});
            end
            m_pos++;
            if (load) begin
                m_hex   = hex_in;
                m_dp    = dp_in;
                m_blank = blank_in;
            end
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++)
            cyc();
    endtask

    task automatic do_load(input logic [31:0] h, input logic [7:0] d,
                           input logic [7:0] b);
        hex_in   = h;
        dp_in    = d;
        blank_in = b;
        load     = 1'b1;
        cyc();
        load     = 1'b0;
    endtask

    initial begin
        glyph_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        m_hex = '0; m_dp = '0; m_blank = '1; m_pos = 0;
        rst = 1'b1; load = 1'b0; hex_in = '0; dp_in = '0; blank_in = '0;
        lz_suppress = 1'b0; brightness = 3'd7;

        // reset, then dark until first load
        run(2);
        rst = 1'b0;
        run(20);

        // basic scan of 12345678 at full brightness
        do_load(32'h12345678, 8'h00, 8'h00);
        run(300);

        // leading-zero suppression
        lz_suppress = 1'b1;
        do_load(32'h00000A00, 8'hA5, 8'h00);
        run(140);
        do_load(32'h00000000, 8'hFF, 8'h00);
        run(140);
        lz_suppress = 1'b0;

        // PWM brightness levels
        do_load(32'h9ABCDEF0, 8'h3C, 8'h00);
        brightness = 3'd2; run(130);
        brightness = 3'd0; run(64);
        brightness = 3'd5; run(64);
        brightness = 3'd7; run(40);

        // reset mid-slot of digit 5, with a simultaneous load ignored
        while ((m_pos % 128) != 5 * 16 + 7) cyc();
        rst = 1'b1;
        load = 1'b1; hex_in = 32'h11111111; blank_in = 8'h00;
        cyc();
        rst = 1'b0; load = 1'b0;
        run(150);
        do_load(32'h87654321, 8'h81, 8'h00);

        // reload digit 3 during its own slot
        while ((m_pos % 128) != 3 * 16 + 5) cyc();
        do_load(32'h8765F321, 8'h81, 8'h00);
        run(200);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                lz_suppress = 1'($urandom);
                brightness  = 3'($urandom);
            end
            if ($urandom_range(0, 599) == 0)
                rst = 1'b1;
            if ($urandom_range(0, 19) == 0) begin
                load     = 1'b1;
                hex_in   = ($urandom_range(0, 1) == 0) ? $urandom
                                                       : ($urandom >> $urandom_range(4, 28));
                dp_in    = 8'($urandom);
                blank_in = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            end
            cyc();
            rst  = 1'b0;
            load = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
